shot_initiator: RTL and testbench

- Initiator side of the shot-exchange protocol between two boards: takes the local player's selected target cell on the guest board and sends it to the opponent over the byte link (header + address).
- Waits for the opponent's hit/miss reply, retrying on timeout.
- Hands the 2-bit result code to the board logic as msg_in, together with a one-cycle result strobe.
- Sits between the mouse/board-select logic and the UART byte TX/RX wrappers.

---
 rtl/shot_initiator.sv | 137 +++++++++++++
 tb/tb_shot_initiator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_initiator.sv
// Initiator side of the shot exchange: sends header + target address over the
// byte link, waits for a tagged hit/miss reply and retries on timeout.
module shot_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 65_000_000,
  parameter int unsigned MAX_TRIES      = 3,
  parameter logic [7:0]  HDR_SHOT       = 8'hC5,
  parameter logic [5:0]  RSP_TAG        = 6'b101010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fire,
  input  logic [7:0] target,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       busy,
  output logic [1:0] msg_in,
  output logic       result_valid,
  output logic       shot_fail,
  output logic       bad_target
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_HDR  = 2'd1,
    SEND_ADDR = 2'd2,
    WAIT_RSP  = 2'd3
  } state_e;

  state_e        state_q;
  logic [7:0]    target_q;
  logic [TW-1:0] timer_q;
  logic [CW-1:0] tries_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          busy_q;
  logic [1:0]    msg_in_q;
  logic          result_valid_q;
  logic          shot_fail_q;
  logic          bad_target_q;

  logic target_ok_c;
  logic rsp_ok_c;
  logic timeout_c;

  assign target_ok_c = (target[7:4] <= 4'd9) && (target[3:0] <= 4'd9);
  assign rsp_ok_c    = rx_valid && (rx_data[7:2] == RSP_TAG) && (rx_data[1:0] != 2'b01);
  assign timeout_c   = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // Protocol FSM with registered outputs; pulse outputs default low each cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      target_q       <= 8'h00;
      timer_q        <= '0;
      tries_q        <= '0;
      tx_data_q      <= 8'h00;
      tx_valid_q     <= 1'b0;
      busy_q         <= 1'b0;
      msg_in_q       <= 2'b00;
      result_valid_q <= 1'b0;
      shot_fail_q    <= 1'b0;
      bad_target_q   <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      shot_fail_q    <= 1'b0;
      bad_target_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fire) begin
            if (target_ok_c) begin
              target_q   <= target;
              tries_q    <= CW'(1);
              busy_q     <= 1'b1;
              tx_data_q  <= HDR_SHOT;
              tx_valid_q <= 1'b1;
              state_q    <= SEND_HDR;
            end else begin
              bad_target_q <= 1'b1;
            end
          end
        end
        SEND_HDR: begin
          // Address follows the header with no idle cycle in between.
          if (tx_ready) begin
            tx_data_q <= target_q;
            state_q   <= SEND_ADDR;
          end
        end
        SEND_ADDR: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            timer_q    <= '0;
            state_q    <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          // A valid reply takes priority over a coincident timeout.
          if (rsp_ok_c) begin
            msg_in_q       <= rx_data[1:0];
            result_valid_q <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end else if (timeout_c) begin
            if (tries_q < CW'(MAX_TRIES)) begin
              tries_q    <= tries_q + CW'(1);
              tx_data_q  <= HDR_SHOT;
              tx_valid_q <= 1'b1;
              state_q    <= SEND_HDR;
            end else begin
              shot_fail_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign busy         = busy_q;
  assign msg_in       = msg_in_q;
  assign result_valid = result_valid_q;
  assign shot_fail    = shot_fail_q;
  assign bad_target   = bad_target_q;

endmodule

// File: tb/tb_shot_initiator.sv
// Scoreboard bench for shot_initiator: stimulus queues expected link/result
// events, a negedge monitor pops and compares whatever the DUT emits.
module tb_shot_initiator;

  localparam int unsigned TO = 100;
  localparam int unsigned MT = 3;

  localparam int K_TX  = 0;
  localparam int K_RES = 1;
  localparam int K_SF  = 2;
  localparam int K_BAD = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fire;
  logic [7:0] target;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic [1:0] msg_in;
  logic       result_valid;
  logic       shot_fail;
  logic       bad_target;

  evt_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  shot_initiator #(
    .TIMEOUT_CYCLES(TO),
    .MAX_TRIES     (MT),
    .HDR_SHOT      (8'hC5),
    .RSP_TAG       (6'b101010)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fire        (fire),
    .target      (target),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .msg_in      (msg_in),
    .result_valid(result_valid),
    .shot_fail   (shot_fail),
    .bad_target  (bad_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input int kind, input logic [7:0] data);
    evt_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic observe(input string name, input int kind, input logic [7:0] data);
    evt_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_%s: got %0h expected no event", name, data);
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, 32'(kind), 32'(e.kind));
      check({name, "_data"}, 32'(data), 32'(e.data));
    end
  endtask

  // Monitor: decode DUT output events and check transmit stability under stall.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (prev_stall) begin
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) observe("tx", K_TX, tx_data);
      if (result_valid) begin
        observe("result", K_RES, 8'(msg_in));
        check("busy_at_result", 32'(busy), 32'd0);
      end
      if (shot_fail) begin
        observe("shotfail", K_SF, 8'h00);
        check("busy_at_shotfail", 32'(busy), 32'd0);
      end
      if (bad_target) observe("badtarget", K_BAD, 8'h00);
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fire(input logic [7:0] t);
    fire   = 1'b1;
    target = t;
    tick();
    fire   = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check({name, "_idle"}, 32'(busy), 32'd0);
    repeat (2) tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    fire     = 1'b0;
    target   = 8'h00;
    tx_ready = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) tick();
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_msg_in", 32'(msg_in), 32'd0);
    check("rst_pulses", 32'({result_valid, shot_fail, bad_target}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Nominal: C5 then 37 back to back, reply AA -> hit.
    push(K_TX, 8'hC5); push(K_TX, 8'h37); push(K_RES, 8'h02);
    do_fire(8'h37);
    check("nom_hdr", 32'({tx_valid, tx_data}), 32'h1C5);
    check("nom_busy", 32'(busy), 32'd1);
    tick();
    check("nom_addr", 32'({tx_valid, tx_data}), 32'h137);
    tick();
    check("nom_wait_txv", 32'(tx_valid), 32'd0);
    tick();
    rx_byte(8'hAA);
    check("nom_rv", 32'({result_valid, msg_in}), 32'h6);
    tick();
    check("nom_rv_once", 32'(result_valid), 32'd0);
    wait_idle("nom", 20);

    // Retry then success: resend exactly after TO waiting cycles, reply A8.
    push(K_TX, 8'hC5); push(K_TX, 8'h37);
    push(K_TX, 8'hC5); push(K_TX, 8'h37); push(K_RES, 8'h00);
    do_fire(8'h37);
    repeat (2) tick();
    repeat (TO - 1) tick();
    check("retry_still_wait", 32'(tx_valid), 32'd0);
    tick();
    check("retry_resend_hdr", 32'({tx_valid, tx_data}), 32'h1C5);
    repeat (8) tick();
    rx_byte(8'hA8);
    wait_idle("retry", 20);
    check("retry_msg", 32'(msg_in), 32'd0);

    // Backpressure: 5-cycle stall on header, 3-cycle stall on address.
    push(K_TX, 8'hC5); push(K_TX, 8'h37); push(K_RES, 8'h03);
    tx_ready = 1'b0;
    do_fire(8'h37);
    repeat (5) tick();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    repeat (3) tick();
    tx_ready = 1'b1;
    tick();
    repeat (2) tick();
    rx_byte(8'hAB);
    wait_idle("bp", 20);
    check("bp_msg", 32'(msg_in), 32'd3);

    // Exhaustion: three attempts, then shot_fail; msg_in keeps 11.
    for (int i = 0; i < int'(MT); i++) begin
      push(K_TX, 8'hC5); push(K_TX, 8'h37);
    end
    push(K_SF, 8'h00);
    do_fire(8'h37);
    wait_idle("exh", 3 * (TO + 10));
    check("exh_msg_kept", 32'(msg_in), 32'd3);

    // Reject out-of-range column, no link activity.
    push(K_BAD, 8'h00);
    do_fire(8'h3A);
    check("bad_no_tx", 32'({tx_valid, busy}), 32'd0);
    repeat (2) tick();

    // Filtering: reserved code and wrong tag discarded, second fire ignored.
    push(K_TX, 8'hC5); push(K_TX, 8'h37); push(K_RES, 8'h03);
    do_fire(8'h37);
    repeat (2) tick();
    do_fire(8'h45);
    rx_byte(8'hA9);
    rx_byte(8'h12);
    check("filt_busy", 32'(busy), 32'd1);
    rx_byte(8'hAB);
    wait_idle("filt", 20);

    // Reset mid-shot: outputs back to reset values, late reply ignored.
    push(K_TX, 8'hC5); push(K_TX, 8'h37);
    do_fire(8'h37);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("mrst_outs", 32'({tx_valid, busy, msg_in, result_valid, shot_fail, bad_target}), 32'd0);
    check("mrst_tx_data", 32'(tx_data), 32'h00);
    rst_n = 1'b1;
    tick();
    rx_byte(8'hAB);
    repeat (3) tick();
    check("mrst_msg", 32'(msg_in), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
